// File: rtl/trig_out_pkg.sv
// trig_out_pkg: shared state encoding, default parameters and saturating increment for trig_out_gen
package trig_out_pkg;
    typedef enum logic {TO_IDLE = 1'b0, TO_HOLD = 1'b1} to_state_e;
    localparam int DEF_N_EV = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_HOLDOFF = 16;
    function automatic logic [15:0] sat_inc(input logic [15:0] value, input int width);
        logic [16:0] max_v;
        max_v = (17'd1 << width) - 17'd1;
        return ({1'b0, value} >= max_v) ? value : value + 16'd1;
    endfunction
endpackage

// File: rtl/trig_ev_counter.sv
// trig_ev_counter: per-event saturating edge counter, sticky coalesce flag and snapshot register
module trig_ev_counter
    import trig_out_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             ev_edge,
    input  logic             coalesce,
    input  logic             snapshot,
    output logic [CNT_W-1:0] cnt_snap,
    output logic             ovf_snap
);
    logic [CNT_W-1:0] cnt_q, cnt_d, snap_cnt_q, snap_cnt_d;
    logic ovf_q, ovf_d, snap_ovf_q, snap_ovf_d;
    always_comb begin
        cnt_d = snapshot ? CNT_W'(ev_edge) : ev_edge ? CNT_W'(sat_inc(16'(cnt_q), CNT_W)) : cnt_q;
        ovf_d = snapshot ? 1'b0 : ovf_q | (ev_edge & coalesce);
        snap_cnt_d = snapshot ? cnt_q : snap_cnt_q;
        snap_ovf_d = snapshot ? ovf_q : snap_ovf_q;
    end
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            snap_cnt_q <= '0;
            snap_ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            snap_cnt_q <= snap_cnt_d;
            snap_ovf_q <= snap_ovf_d;
        end
    end
    assign cnt_snap = snap_cnt_q;
    assign ovf_snap = snap_ovf_q;
endmodule

// File: rtl/trig_out_gen.sv
// trig_out_gen: rate-limited event-to-trigger-out reporter; edge counters built only with TRIG_OUT_CNT_EN
module trig_out_gen
    import trig_out_pkg::*;
#(
    parameter int N_EV = DEF_N_EV,
    parameter int CNT_W = DEF_CNT_W,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [N_EV-1:0]       ev_in,
    input  logic                  snapshot,
    output logic [N_EV-1:0]       trig_out,
    output logic [N_EV*CNT_W-1:0] ev_cnt,
    output logic [N_EV-1:0]       ev_ovf,
    output logic                  busy
);
    localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF - 1);
    logic [N_EV-1:0] ev_q, ev_edge, pending_q, pending_d, trig_q, trig_d;
    logic [HW-1:0] hold_q, hold_d;
    to_state_e state_q, state_d;
    logic fire;
    assign ev_edge = ev_in & ~ev_q;
    always_comb begin
        fire = (state_q == TO_IDLE) && (pending_q != '0);
        pending_d = fire ? ev_edge : pending_q | ev_edge;
        trig_d = fire ? pending_q : '0;
        state_d = fire ? TO_HOLD : (state_q == TO_HOLD && hold_q == '0) ? TO_IDLE : state_q;
        hold_d = fire ? HOLD_INIT : (state_q == TO_HOLD && hold_q != '0) ? hold_q - 1'b1 : hold_q;
    end
    always_ff @(posedge sys_clk) begin
        ev_q <= ev_in;
        if (reset) begin
            pending_q <= '0;
            trig_q <= '0;
            hold_q <= '0;
            state_q <= TO_IDLE;
        end else begin
            pending_q <= pending_d;
            trig_q <= trig_d;
            hold_q <= hold_d;
            state_q <= state_d;
        end
    end
    assign trig_out = trig_q;
    assign busy = state_q == TO_HOLD;
`ifdef TRIG_OUT_CNT_EN
    for (genvar i = 0; i < N_EV; i++) begin : g_cnt
        trig_ev_counter #(.CNT_W(CNT_W)) u_cnt (
            .sys_clk  (sys_clk),
            .reset    (reset),
            .ev_edge  (ev_edge[i]),
            .coalesce (pending_q[i] & ~fire),
            .snapshot (snapshot),
            .cnt_snap (ev_cnt[i*CNT_W +: CNT_W]),
            .ovf_snap (ev_ovf[i])
        );
    end
`else
    logic unused_snapshot;
    assign unused_snapshot = snapshot;
    assign ev_cnt = '0;
    assign ev_ovf = '0;
`endif
endmodule

// File: tb/tb_trig_out_gen.sv
// tb_trig_out_gen: directed and random stimulus against a cycle-level behavioural model of trig_out_gen
module tb_trig_out_gen;
    localparam int N_EV = 8;
    localparam int CNT_W = 8;
    localparam int HOLDOFF = 16;
    localparam int CMAX = 255;
`ifdef TRIG_OUT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic sys_clk = 1'b0;
    logic reset = 1'b1;
    logic snapshot = 1'b0;
    logic [N_EV-1:0] ev_in = '0;
    logic [N_EV-1:0] trig_out, ev_ovf;
    logic [N_EV*CNT_W-1:0] ev_cnt;
    logic busy;
    int errors = 0;
    int checks = 0;
    logic [7:0] m_prev = '0;
    logic [7:0] m_pend, m_trig, m_ovf, m_snap_ovf;
    int m_hold;
    int m_cnt[8];
    int m_snap_cnt[8];
    always #5 sys_clk = ~sys_clk;
    trig_out_gen #(.N_EV(N_EV), .CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .ev_in    (ev_in),
        .snapshot (snapshot),
        .trig_out (trig_out),
        .ev_cnt   (ev_cnt),
        .ev_ovf   (ev_ovf),
        .busy     (busy)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Reference: holdoff is a countdown of cycles left before a fire is allowed again.
    task automatic model_step(input logic [7:0] ev, input logic sn, input logic r);
        logic [7:0] e, fmask;
        e = ev & ~m_prev;
        m_prev = ev;
        if (r) begin
            m_pend = '0;
            m_trig = '0;
            m_ovf = '0;
            m_snap_ovf = '0;
            m_hold = 0;
            for (int i = 0; i < 8; i++) begin
                m_cnt[i] = 0;
                m_snap_cnt[i] = 0;
            end
        end else begin
            fmask = (m_hold == 0) ? m_pend : 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (sn) begin
                    m_snap_cnt[i] = m_cnt[i];
                    m_cnt[i] = e[i] ? 1 : 0;
                end else if (e[i] && m_cnt[i] < CMAX) begin
                    m_cnt[i]++;
                end
            end
            if (sn) begin
                m_snap_ovf = m_ovf;
                m_ovf = '0;
            end else begin
                m_ovf = m_ovf | (e & m_pend & ~fmask);
            end
            m_trig = fmask;
            if (fmask != 0) begin
                m_pend = e;
                m_hold = HOLDOFF;
            end else begin
                m_pend = m_pend | e;
                if (m_hold > 0) m_hold--;
            end
        end
    endtask
    function automatic logic [63:0] exp_cnt();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = CNT_EN ? 8'(m_snap_cnt[i]) : 8'h00;
        return v;
    endfunction
    task automatic step(input logic [7:0] ev, input logic sn, input logic r);
        ev_in = ev;
        snapshot = sn;
        reset = r;
        @(posedge sys_clk);
        model_step(ev, sn, r);
        #1;
        check("trig_out", 64'(trig_out), 64'(m_trig));
        check("busy", 64'(busy), 64'(m_hold != 0));
        check("ev_cnt", ev_cnt, exp_cnt());
        check("ev_ovf", 64'(ev_ovf), CNT_EN ? 64'(m_snap_ovf) : 64'h0);
    endtask
    initial begin
        logic [7:0] cur;
        repeat (3) step(8'h00, 1'b0, 1'b1);
        check("reset_trig", 64'(trig_out), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        repeat (9) step(8'h00, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check("basic_trig", 64'(trig_out), 64'h01);
        check("basic_busy", 64'(busy), 64'h1);
        step(8'h00, 1'b0, 1'b0);
        check("basic_one_cycle", 64'(trig_out), 64'h0);
        repeat (20) step(8'h00, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        repeat (3) begin
            step(8'h08, 1'b0, 1'b0);
            step(8'h00, 1'b0, 1'b0);
        end
        repeat (20) step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        check("coal_cnt3", 64'(ev_cnt[31:24]), CNT_EN ? 64'd3 : 64'd0);
        check("coal_ovf3", 64'(ev_ovf[3]), CNT_EN ? 64'd1 : 64'd0);
        repeat (300) begin
            step(8'h02, 1'b0, 1'b0);
            step(8'h00, 1'b0, 1'b0);
        end
        step(8'h00, 1'b1, 1'b0);
        check("sat_cnt1", 64'(ev_cnt[15:8]), CNT_EN ? 64'd255 : 64'd0);
        repeat (20) step(8'h00, 1'b0, 1'b0);
        step(8'h04, 1'b1, 1'b0);
        check("coll_cnt2_a", 64'(ev_cnt[23:16]), 64'd0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        check("coll_cnt2_b", 64'(ev_cnt[23:16]), CNT_EN ? 64'd1 : 64'd0);
        repeat (3) step(8'hFF, 1'b0, 1'b1);
        repeat (25) step(8'hFF, 1'b0, 1'b0);
        step(8'hFF, 1'b1, 1'b0);
        check("lvl_cnt", ev_cnt, 64'h0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h80, 1'b0, 1'b0);
        step(8'h80, 1'b0, 1'b0);
        check("lvl_trig7", 64'(trig_out), 64'h80);
        repeat (20) step(8'h00, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h05, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b1);
        check("rst_hold_busy", 64'(busy), 64'h0);
        repeat (25) step(8'h00, 1'b0, 1'b0);
        check("rst_hold_trig", 64'(trig_out), 64'h0);
        cur = 8'h00;
        repeat (3000) begin
            cur = cur ^ 8'($urandom & $urandom & $urandom);
            step(cur, $urandom_range(0, 31) == 0, $urandom_range(0, 499) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
